// File: rtl/gray_step_ctrl.sv
// Step-command sequencer for the shared gray_counter: issues ena/clear, waits out the
// counter's bin->gray lag, reports the settled value and flags gray-code integrity faults.
module gray_step_ctrl #(
  parameter int N_BITS = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_clr,
  input  logic              cmd_loop,
  input  logic              abort,
  output logic              cnt_ena,
  output logic              cnt_clr_n,
  input  logic [N_BITS-1:0] gray_cnt,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] done_gray,
  output logic [LEN_W-1:0]  steps_done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [LEN_W-1:0]   len_rem;
  logic [LEN_W-1:0]   step_cnt;
  logic               loop_q;
  logic               settle_q;
  logic [N_BITS-1:0]  shadow;
  logic [N_BITS-1:0]  prev_gray;
  logic               prev_vld;
  logic               in_chk;
  logic               settle_last;
  logic [N_BITS-1:0]  flip;
  logic               multi_flip;
  logic               final_bad;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cmd_ready = 1'b0;
    cnt_ena   = 1'b0;
    cnt_clr_n = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_clr)                         state_nxt = S_CLEAR;
          else if (cmd_loop || cmd_len != '0)  state_nxt = S_RUN;
          else                                 state_nxt = S_SETTLE;
        end
      end
      S_CLEAR: begin
        cnt_clr_n = 1'b0;
        state_nxt = (loop_q || len_rem != '0) ? S_RUN : S_SETTLE;
      end
      S_RUN: begin
        // abort wins over the step: that cycle issues no ena
        if (abort) begin
          state_nxt = S_SETTLE;
        end else begin
          cnt_ena = 1'b1;
          if (!loop_q && len_rem == LEN_W'(1)) state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_chk      = (state == S_RUN) || (state == S_SETTLE);
  assign settle_last = (state == S_SETTLE) && settle_q;
  // more than one bit set <=> clearing the lowest set bit leaves something
  assign flip        = gray_cnt ^ prev_gray;
  assign multi_flip  = (flip & (flip - 1'b1)) != '0;
  assign final_bad   = gray_cnt != (shadow ^ (shadow >> 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IDLE;
      len_rem    <= '0;
      step_cnt   <= '0;
      loop_q     <= 1'b0;
      settle_q   <= 1'b0;
      shadow     <= '0;
      prev_gray  <= '0;
      prev_vld   <= 1'b0;
      done_gray  <= '0;
      steps_done <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        len_rem  <= cmd_len;
        loop_q   <= cmd_loop;
        step_cnt <= '0;
      end
      if (state == S_CLEAR) shadow <= '0;
      if (cnt_ena) begin
        shadow   <= shadow + 1'b1;
        step_cnt <= step_cnt + 1'b1;
        len_rem  <= len_rem - 1'b1;
      end
      settle_q <= (state == S_SETTLE) ? ~settle_q : 1'b0;
      if (settle_last) begin
        done_gray  <= gray_cnt;
        steps_done <= step_cnt;
      end
      // history is only trusted inside one command's RUN/SETTLE window
      prev_gray <= gray_cnt;
      prev_vld  <= in_chk;
      if ((in_chk && prev_vld && multi_flip) || (settle_last && final_bad)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl: behavioural gray_counter model, table of commands with a
// scoreboard queue of expected completions, plus hand-written reset sequences.
module tb_gray_step_ctrl;
  localparam int N_BITS = 4;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              cmd_clr = 1'b0;
  logic              cmd_loop = 1'b0;
  logic              abort = 1'b0;
  logic              cnt_ena;
  logic              cnt_clr_n;
  logic [N_BITS-1:0] gray_cnt;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] done_gray;
  logic [LEN_W-1:0]  steps_done;
  logic              err;

  logic [N_BITS-1:0] g_bin, g_gray;
  logic              force_en = 1'b0;
  int                cyc = 0;
  int                tests = 0;
  int                fails = 0;

  typedef struct {
    int len; int clr; int loop; int abort_off; int hold; int frc;
    int exp_gray; int exp_steps; int exp_lat; int exp_err;
  } vec_t;
  typedef struct { int gray; int steps; int lat; } exp_t;

  vec_t tbl[6];
  vec_t v0;
  exp_t sbq[$];

  gray_step_ctrl #(.N_BITS(N_BITS), .LEN_W(LEN_W)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_clr(cmd_clr), .cmd_loop(cmd_loop), .abort(abort),
    .cnt_ena(cnt_ena), .cnt_clr_n(cnt_clr_n), .gray_cnt(gray_cnt), .busy(busy),
    .done(done), .done_gray(done_gray), .steps_done(steps_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // gray_counter model: binary count plus one-cycle-late registered gray
  always @(posedge clk) begin
    if (!(nrst && cnt_clr_n)) begin
      g_bin  <= '0;
      g_gray <= '0;
    end else begin
      if (cnt_ena) g_bin <= g_bin + 1'b1;
      g_gray <= g_bin ^ (g_bin >> 1);
    end
  end
  assign gray_cnt = force_en ? N_BITS'(7) : g_gray;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int t, enas, extra, seen, arm;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(v.len);
    cmd_clr   = v.clr[0];
    cmd_loop  = v.loop[0];
    #1;
    chk("ready_at_offer", idx, cmd_ready, 1);
    t = cyc;
    sbq.push_back('{v.exp_gray, v.exp_steps, v.exp_lat});
    enas = 0; extra = 0; seen = 0; arm = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(negedge clk);
      if (v.hold == 0) cmd_valid = 1'b0;
      abort    = (v.abort_off != 0) && (cyc == t + v.abort_off);
      force_en = (arm != 0) && (cyc == arm);
      #1;
      if (cnt_ena) enas++;
      if (cmd_valid && cmd_ready) extra++;
      if (v.clr != 0 && cyc == t + 1) chk("clr_pulse", idx, cnt_clr_n, 0);
      if (v.frc != 0 && arm != 0 && cyc == arm)     chk("err_before_fault", idx, err, 0);
      if (v.frc != 0 && arm != 0 && cyc == arm + 1) chk("err_after_fault", idx, err, 1);
      if (v.frc != 0 && arm == 0 && busy && g_gray == N_BITS'(1)) arm = cyc + 1;
      if (done) begin
        seen = 1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("latency", idx, cyc - t, e.lat);
          chk("done_gray", idx, done_gray, e.gray);
          chk("steps_done", idx, steps_done, e.steps);
          chk("ena_cycles", idx, enas, e.steps);
        end
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    force_en  = 1'b0;
    if (seen == 0) begin
      chk("done_timeout", idx, 0, 1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    chk("no_accept_while_busy", idx, extra, 0);
    @(negedge clk); #1;
    chk("idle_busy", idx, busy, 0);
    chk("idle_done", idx, done, 0);
    chk("held_gray", idx, done_gray, v.exp_gray);
    chk("err", idx, err, v.exp_err);
  endtask

  initial begin
    //          len clr loop abrt hold frc  gray steps lat err
    tbl[0] = '{  5,  1,  0,   0,   0,   0,  7,   5,    9,  0};
    tbl[1] = '{ 12,  0,  0,   0,   0,   0,  1,  12,   15,  0};
    tbl[2] = '{  0,  1,  1,   4,   0,   0,  3,   2,    7,  0};
    tbl[3] = '{ 16,  1,  0,   0,   1,   0,  0,  16,   20,  0};
    tbl[4] = '{  8,  1,  0,   0,   0,   1, 12,   8,   12,  1};
    tbl[5] = '{  3,  0,  0,   0,   0,   0, 14,   3,    6,  1};
    v0     = '{  0,  0,  0,   0,   0,   0,  0,   0,    3,  0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", -1, cmd_ready, 1);
    chk("rst_busy", -1, busy, 0);
    chk("rst_ena", -1, cnt_ena, 0);
    chk("rst_clr_n", -1, cnt_clr_n, 1);
    chk("rst_done", -1, done, 0);
    chk("rst_done_gray", -1, done_gray, 0);
    chk("rst_steps", -1, steps_done, 0);
    chk("rst_err", -1, err, 0);
    nrst = 1'b1;

    foreach (tbl[i]) run_cmd(tbl[i], i);

    // reset in the middle of a long command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = LEN_W'(20); cmd_clr = 1'b0; cmd_loop = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrun_ena", 6, cnt_ena, 1);
    nrst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_ena", 6, cnt_ena, 0);
    chk("midrst_busy", 6, busy, 0);
    chk("midrst_err", 6, err, 0);
    chk("midrst_steps", 6, steps_done, 0);
    nrst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", 6, cmd_ready, 1);

    run_cmd(v0, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
